// File: rtl/slice_serial_adder_pkg.sv
// Shared definitions for the slice-serial adder: slice width, FSM encoding and sizing helpers.
package slice_serial_adder_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Slice counter needs at least one bit even when there is only a single slice.
  function automatic int cnt_width(input int num_slices);
    return (num_slices > 1) ? $clog2(num_slices) : 1;
  endfunction

endpackage

// File: rtl/slice_serial_adder_if.sv
// Operand/result bus of the slice-serial adder. Both sides use valid/ready: a transfer
// happens on a rising edge where valid and ready are both 1; valid, once raised, holds its payload until that edge.
interface slice_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SLICE_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin,
`ifdef SLICE_ADDER_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef SLICE_ADDER_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/slice_serial_adder_rca_4_bit.sv
// Four-bit ripple-carry adder used as the per-cycle slice datapath.
module rca_4_bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  always_comb begin
    logic c;
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < 4; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/slice_serial_adder.sv
// Multi-cycle WIDTH-bit adder feeding one 4-bit slice per clock through rca_4_bit.
// Define SLICE_ADDER_SUB_EN to add a 'sub' input selecting a - b.
module slice_serial_adder
  import slice_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  slice_serial_adder_if.slave   bus_io,
  output state_e                state_o
);

  localparam int NS    = WIDTH / SLICE_W;
  localparam int CNT_W = cnt_width(NS);

  generate
    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
      $error("slice_serial_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q, b_q, sum_q;
  logic               carry_q;
  logic               a_sign_q, b_sign_q;
  logic               ovf_q;

  logic [WIDTH-1:0]   b_eff_w;
  logic               carry_init_w;
  logic               accept_w;
  logic               last_slice_w;
  logic [SLICE_W-1:0] slice_sum_w;
  logic               slice_cout_w;
  logic [WIDTH-1:0]   sum_shift_w;

`ifdef SLICE_ADDER_SUB_EN
  // Subtraction is a + ~b + 1, so the incoming carry is forced high.
  assign b_eff_w      = bus_io.sub ? ~bus_io.b : bus_io.b;
  assign carry_init_w = bus_io.sub ? 1'b1 : bus_io.cin;
`else
  assign b_eff_w      = bus_io.b;
  assign carry_init_w = bus_io.cin;
`endif

  assign accept_w     = bus_io.in_valid && (state_q == ST_IDLE);
  assign last_slice_w = (cnt_q == CNT_W'(NS - 1));

  rca_4_bit u_rca (
    .a_i    (a_q[SLICE_W-1:0]),
    .b_i    (b_q[SLICE_W-1:0]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum_w),
    .cout_o (slice_cout_w)
  );

  // Result slices enter at the top, so after NS shifts slice 0 sits at the bottom.
  always_comb begin
    sum_shift_w                    = sum_q >> SLICE_W;
    sum_shift_w[WIDTH-1 -: SLICE_W] = slice_sum_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus_io.in_valid) state_d = ST_RUN;
      ST_RUN:  if (last_slice_w)    state_d = ST_DONE;
      ST_DONE: if (bus_io.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept_w) begin
      cnt_q    <= '0;
      a_q      <= bus_io.a;
      b_q      <= b_eff_w;
      carry_q  <= carry_init_w;
      a_sign_q <= bus_io.a[WIDTH-1];
      b_sign_q <= b_eff_w[WIDTH-1];
    end else if (state_q == ST_RUN) begin
      cnt_q   <= cnt_q + CNT_W'(1);
      a_q     <= a_q >> SLICE_W;
      b_q     <= b_q >> SLICE_W;
      sum_q   <= sum_shift_w;
      carry_q <= slice_cout_w;
      // The MSB slice's top bit is the result sign.
      if (last_slice_w) begin
        ovf_q <= (a_sign_q == b_sign_q) && (slice_sum_w[SLICE_W-1] != a_sign_q);
      end
    end
  end

  always_comb begin
    bus_io.in_ready  = (state_q == ST_IDLE);
    bus_io.out_valid = (state_q == ST_DONE);
    bus_io.sum       = sum_q;
    bus_io.cout      = carry_q;
    bus_io.ovf       = ovf_q;
    state_o          = state_q;
  end

endmodule

// File: tb/tb_slice_serial_adder.sv
// Directed bench for slice_serial_adder: 16-bit and 4-bit instances with scoreboarded results.
module tb_slice_serial_adder;
  import slice_serial_adder_pkg::*;

  logic   clk;
  logic   rst_n;
  state_e state16, state4;
  int     n_checks = 0;
  int     n_pass   = 0;

  logic [17:0] exp16_q[$];
  logic [5:0]  exp4_q[$];
  logic [17:0] e16;
  logic [5:0]  e4;

  slice_serial_adder_if #(.WIDTH(16)) bus16 ();
  slice_serial_adder_if #(.WIDTH(4))  bus4 ();

  slice_serial_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus_io(bus16.slave), .state_o(state16));
  slice_serial_adder #(.WIDTH(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus_io(bus4.slave),  .state_o(state4));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, act=running req=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: act=missing req=present", name);
  endtask

  // driver tasks
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic push, input logic [17:0] exp);
    int t = 0;
    @(negedge clk);
    while (!bus16.in_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail_now("send16_in_ready_timeout");
    bus16.a = a; bus16.b = b; bus16.cin = cin;
`ifdef SLICE_ADDER_SUB_EN
    bus16.sub = sub;
`else
    if (sub) $display("note: sub requested in a build without subtraction");
`endif
    bus16.in_valid = 1'b1;
    if (push) exp16_q.push_back(exp);
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic [5:0] exp);
    int t = 0;
    @(negedge clk);
    while (!bus4.in_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail_now("send4_in_ready_timeout");
    bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.in_valid = 1'b1;
    exp4_q.push_back(exp);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp16_q.size() != 0 || exp4_q.size() != 0) && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) fail_now("drain_timeout");
    @(negedge clk);
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst_n && bus16.out_valid && bus16.out_ready) begin
      if (exp16_q.size() == 0) fail_now("mon16_unexpected_result");
      else begin
        e16 = exp16_q.pop_front();
        check("mon16_sum",  32'(bus16.sum), 32'(e16[15:0]));
        check("mon16_ovf",  32'(bus16.ovf), 32'(e16[16]));
        check("mon16_cout", 32'(bus16.cout), 32'(e16[17]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus4.out_valid && bus4.out_ready) begin
      if (exp4_q.size() == 0) fail_now("mon4_unexpected_result");
      else begin
        e4 = exp4_q.pop_front();
        check("mon4_sum",  32'(bus4.sum), 32'(e4[3:0]));
        check("mon4_ovf",  32'(bus4.ovf), 32'(e4[4]));
        check("mon4_cout", 32'(bus4.cout), 32'(e4[5]));
      end
    end
  end

  // stimulus; expected words are {cout, ovf, sum}
  initial begin
    rst_n = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.out_ready = 1'b1;
    bus4.in_valid  = 1'b0; bus4.a  = '0; bus4.b  = '0; bus4.cin  = 1'b0; bus4.out_ready  = 1'b1;
`ifdef SLICE_ADDER_SUB_EN
    bus16.sub = 1'b0; bus4.sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(bus16.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus16.out_valid), 32'd0);
    check("rst_sum",       32'(bus16.sum), 32'd0);
    check("rst_cout",      32'(bus16.cout), 32'd0);
    check("rst_ovf",       32'(bus16.ovf), 32'd0);
    check("rst4_in_ready", 32'(bus4.in_ready), 32'd1);
    rst_n = 1'b1;

    // basic add with exact latency of four edges
    send16(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 16'h5555});
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check("latency_not_yet_valid", 32'(bus16.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    check("latency_valid_at_4", 32'(bus16.out_valid), 32'd1);
    wait_drain();

    send16(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0000});
    wait_drain();
    send16(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, {1'b1, 1'b1, 16'h0000});
    send16(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 16'h1000});
    wait_drain();

    // overflow result held under back-pressure while new requests are ignored
    bus16.out_ready = 1'b0;
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 16'h8000});
    begin
      int t = 0;
      while (!bus16.out_valid && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) fail_now("hold_out_valid_timeout");
    end
    bus16.a = 16'h1111; bus16.b = 16'h2222; bus16.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(bus16.out_valid), 32'd1);
      check("hold_in_ready",  32'(bus16.in_ready), 32'd0);
      check("hold_sum",       32'(bus16.sum), 32'h8000);
    end
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    wait_drain();

    // asynchronous reset while slice 2 is in progress
    send16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 18'd0);
    @(posedge clk); @(posedge clk); #1;
    check("abort_in_run", 32'(state16), 32'(ST_RUN));
    rst_n = 1'b0;
    #1;
    check("abort_in_ready",  32'(bus16.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus16.out_valid), 32'd0);
    check("abort_sum",       32'(bus16.sum), 32'd0);
    check("abort_cout",      32'(bus16.cout), 32'd0);
    check("abort_ovf",       32'(bus16.ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send16(16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 16'h0007});
    wait_drain();

`ifdef SLICE_ADDER_SUB_EN
    // cin is ignored when subtracting
    send16(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    send16(16'h0009, 16'h0004, 1'b0, 1'b1, 1'b1, {1'b1, 1'b0, 16'h0005});
    wait_drain();
`endif

    // single-slice instance
    send4(4'd9, 4'd8, 1'b0, {1'b1, 1'b1, 4'd1});
    @(posedge clk); #1;
    check("w4_one_run_cycle", 32'(bus4.out_valid), 32'd1);
    wait_drain();
    send4(4'd3, 4'd4, 1'b1, {1'b0, 1'b1, 4'd8});
    wait_drain();

    check("queues_empty", 32'(exp16_q.size() + exp4_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
